// File: rtl/fifo_umbral_if.sv
// Handshake, threshold and status bundle between the flow-control FSM and one FIFO instance.
// The FSM side (or a testbench) takes the master modport; the FIFO takes the slave modport.
interface fifo_umbral_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] th_almost_empty;
  logic [ADDR_WIDTH-1:0] th_almost_full;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output push, pop, data_in, th_almost_empty, th_almost_full,
    input  data_out, valid_out, fifo_empty, fifo_full,
    input  almost_empty, almost_full, overflow_err, underflow_err
  );

  modport slave (
    input  push, pop, data_in, th_almost_empty, th_almost_full,
    output data_out, valid_out, fifo_empty, fifo_full,
    output almost_empty, almost_full, overflow_err, underflow_err
  );
endinterface

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-empty / almost-full thresholds.
// Registered read data, one-cycle error pulses, status flags decoded from the registered count.
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic          clk,
  input  logic          reset,
  fifo_umbral_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_overflow_err;
  logic                  r_underflow_err;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [ADDR_WIDTH:0]   w_count_next;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_CNT);

  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  assign w_push_ok = bus.push & (~w_full | bus.pop);
  assign w_pop_ok  = bus.pop & ~w_empty;

  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_data_out      <= '0;
      r_valid_out     <= 1'b0;
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      r_count         <= w_count_next;
      r_valid_out     <= w_pop_ok;
      r_overflow_err  <= bus.push & ~w_push_ok;
      r_underflow_err <= bus.pop & w_empty;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_data_out <= r_mem[r_rd_ptr];
      end
    end
  end

  assign bus.data_out      = r_data_out;
  assign bus.valid_out     = r_valid_out;
  assign bus.overflow_err  = r_overflow_err;
  assign bus.underflow_err = r_underflow_err;
  assign bus.fifo_empty    = w_empty;
  assign bus.fifo_full     = w_full;
  // Thresholds are live inputs, so a change shows on the flags without waiting for a clock.
  assign bus.almost_empty  = (r_count <= {1'b0, bus.th_almost_empty});
  assign bus.almost_full   = (r_count >= {1'b0, bus.th_almost_full});
endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Synchronous FIFO with programmable almost-empty and almost-full thresholds.
- Sits directly downstream of the flow-control FSM. The FSM drives th_almost_empty and th_almost_full into each FIFO instance.
- Each instance returns fifo_empty (one bit of the FSM's fifos_empty bus), almost_empty and almost_full (bits of the FSM's th_fifos_almost_empty and th_fifos_almost_full buses).
- Data path: single write port and single read port; read data is registered.

Parameters:
- DATA_WIDTH, 6, width of each stored word.
- ADDR_WIDTH, 3, pointer width. Depth is 2**ADDR_WIDTH (8). Threshold width equals ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  write request; data_in is written this cycle if accepted.
- pop  input  1  read request.
- data_in  input  DATA_WIDTH  write data.
- th_almost_empty  input  ADDR_WIDTH  almost-empty threshold, from the FSM.
- th_almost_full  input  ADDR_WIDTH  almost-full threshold, from the FSM.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  high for one cycle when data_out carries a newly popped word.
- fifo_empty  output  1  high when count == 0.
- fifo_full  output  1  high when count == 2**ADDR_WIDTH.
- almost_empty  output  1  high when count <= th_almost_empty.
- almost_full  output  1  high when count >= th_almost_full.
- overflow_err  output  1  one-cycle pulse on a rejected push.
- underflow_err  output  1  one-cycle pulse on a rejected pop.

Behaviour:
- State: wr_ptr and rd_ptr, each ADDR_WIDTH bits, wrap modulo depth. count is ADDR_WIDTH+1 bits, range 0..depth. Storage array is not reset.
- Reset (reset=1 at posedge) sets:
  - wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, overflow_err=0, underflow_err=0.
  - Combinational flags follow from count=0: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=(th_almost_full==0).
  - Reset overrides push/pop in the same cycle. Reset mid-operation discards all contents.
- Accept rules, evaluated on registered count at posedge:
  - push_ok = push & (~fifo_full | pop).
  - pop_ok = pop & ~fifo_empty.
- Full with push+pop: both accepted; count unchanged; no overflow_err.
- Empty with push+pop: push accepted; pop rejected with underflow_err=1; count becomes 1. The written word is not bypassed to data_out.
- On push_ok: mem[wr_ptr] <= data_in; wr_ptr increments and wraps 7 -> 0.
- On pop_ok: data_out <= mem[rd_ptr]; rd_ptr increments and wraps; valid_out=1 next cycle. Read latency is 1 clock from pop to data_out.
- When pop_ok is 0: valid_out=0 and data_out holds its last value.
- count_next = count + push_ok - pop_ok.
- overflow_err = push & ~push_ok, registered as a one-cycle pulse.
- underflow_err = pop & fifo_empty, registered as a one-cycle pulse.
- Flags are combinational from registered count and the live threshold inputs. The FSM keeps thresholds stable outside its init phase. A threshold change takes effect on the flags in the same cycle.
- Threshold comparisons are unsigned. Consequences:
  - th_almost_full=0 forces almost_full=1.
  - th_almost_empty=7 with depth 8 gives almost_empty=1 except when full.
- Flags are not mutually exclusive. When the thresholds overlap, almost_empty and almost_full may both be high.

Test Plan:
- Reset: assert reset 2 cycles with th_almost_empty=1, th_almost_full=7 -> fifo_empty=1, almost_empty=1, almost_full=0, fifo_full=0, valid_out=0, data_out=0.
- Fill: th_almost_empty=2, th_almost_full=5; push 8 words 0x01..0x08 -> fifo_empty falls after the 1st push; almost_empty falls after the 3rd; almost_full rises after the 5th; fifo_full=1 after the 8th. A 9th push gives overflow_err=1 for one cycle with count staying 8.
- Drain and order: from full, pop 8 times -> data_out=0x01..0x08 in order, each one cycle after its pop with valid_out=1. Then fifo_empty=1; a further pop gives underflow_err=1 and valid_out=0.
- Simultaneous: at count=8 push 0x2A and pop -> count stays 8, no overflow_err, data_out=oldest word. At count=0 push 0x15 and pop -> count=1, underflow_err=1, valid_out=0.
- Wrap-around: push 5, pop 5, push 6, pop 6 -> pointers wrap 7 -> 0; data returned in exact push order; final fifo_empty=1.
- Threshold change and mid-op reset: at count=4 change thresholds 3/5 -> 1/3; almost_full rises the same cycle. Then assert reset with push=1 -> count=0, fifo_empty=1, the push is ignored.
